alu_share_arb: RTL and testbench

//  Shares one combinational ALU instance between two requesters (req0 = EX-stage

---
 rtl/alu_share_arb_pkg.sv | 28 ++
 rtl/alu_share_arb_alu.sv | 38 +++
 rtl/alu_share_arb.sv | 125 ++++++++++++
 tb/tb_alu_share_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// ============================================================================
// alu_share_arb_pkg : shared ALU widths, op codes and arbiter ids
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_share_arb_pkg;

   localparam int DATA_WIDTH_GPR    = 32;
   localparam int DATA_WIDTH_ALU_OP = 4;

   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_ADD  = 4'd0;
   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SUB  = 4'd1;
   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_AND  = 4'd2;
   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_OR   = 4'd3;
   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_XOR  = 4'd4;
   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLL  = 4'd5;
   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRL  = 4'd6;
   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SRA  = 4'd7;
   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLT  = 4'd8;
   localparam logic [DATA_WIDTH_ALU_OP-1:0] ALU_OP_SLTU = 4'd9;

   localparam logic ARB_ID_EX  = 1'b0;
   localparam logic ARB_ID_AGU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_share_arb_alu.sv
// ============================================================================
// alu_share_arb_alu : combinational integer ALU, unknown op codes yield 0
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_share_arb_alu
   import alu_share_arb_pkg::*;
(
   input  logic [DATA_WIDTH_ALU_OP-1:0] i_op,
   input  logic [DATA_WIDTH_GPR-1:0]    i_in_0,
   input  logic [DATA_WIDTH_GPR-1:0]    i_in_1,
   output logic [DATA_WIDTH_GPR-1:0]    o_result
);

   logic [4:0] w_shamt;
   assign w_shamt = i_in_1[4:0];

   always_comb begin
      o_result = '0;
      case (i_op)
         ALU_OP_ADD:  o_result = i_in_0 + i_in_1;
         ALU_OP_SUB:  o_result = i_in_0 - i_in_1;
         ALU_OP_AND:  o_result = i_in_0 & i_in_1;
         ALU_OP_OR:   o_result = i_in_0 | i_in_1;
         ALU_OP_XOR:  o_result = i_in_0 ^ i_in_1;
         ALU_OP_SLL:  o_result = i_in_0 << w_shamt;
         ALU_OP_SRL:  o_result = i_in_0 >> w_shamt;
         ALU_OP_SRA:  o_result = $signed(i_in_0) >>> w_shamt;
         ALU_OP_SLT:  o_result = {{(DATA_WIDTH_GPR-1){1'b0}}, ($signed(i_in_0) < $signed(i_in_1))};
         ALU_OP_SLTU: o_result = {{(DATA_WIDTH_GPR-1){1'b0}}, (i_in_0 < i_in_1)};
         default:     o_result = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_share_arb.sv
// ============================================================================
// alu_share_arb : round-robin sharing of one ALU between two requesters,
//                 results returned in order through a small tagged FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_share_arb
   import alu_share_arb_pkg::*;
#(
   parameter int TAG_W     = 4,
   parameter int RSP_DEPTH = 2,
   parameter int RR_INIT   = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     req_valid,
   output logic [1:0]                     req_ready,
   input  logic [2*DATA_WIDTH_ALU_OP-1:0] req_op,
   input  logic [2*DATA_WIDTH_GPR-1:0]    req_in_0,
   input  logic [2*DATA_WIDTH_GPR-1:0]    req_in_1,
   input  logic [2*TAG_W-1:0]             req_tag,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic                           rsp_id,
   output logic [TAG_W-1:0]               rsp_tag,
   output logic [DATA_WIDTH_GPR-1:0]      rsp_data,
   output logic                           busy
);

   localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_PLD_W = 1 + TAG_W + DATA_WIDTH_GPR;
   localparam logic c_RR_INIT = (RR_INIT != 0);

   logic [c_PLD_W-1:0] r_mem [RSP_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               r_prio;

   logic                         w_pop;
   logic                         w_push;
   logic                         w_can_accept;
   logic [1:0]                   w_grant;
   logic                         w_sel;
   logic [DATA_WIDTH_ALU_OP-1:0] w_op;
   logic [DATA_WIDTH_GPR-1:0]    w_in_0;
   logic [DATA_WIDTH_GPR-1:0]    w_in_1;
   logic [TAG_W-1:0]             w_tag;
   logic [DATA_WIDTH_GPR-1:0]    w_result;
   logic [c_PLD_W-1:0]           w_push_pld;
   logic [c_PLD_W-1:0]           w_head;

   assign rsp_valid = (r_count != '0);
   assign busy      = rsp_valid;
   assign w_pop     = rsp_valid & rsp_ready;
   // Nothing is granted while reset is held, so no op can be lost across reset.
   assign w_can_accept = !rst && ((r_count < c_CNT_W'(RSP_DEPTH)) || w_pop);

   always_comb begin
      w_grant = 2'b00;
      if (w_can_accept) begin
         case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
            default: w_grant = 2'b00;
         endcase
      end
   end

   assign req_ready = w_grant;
   assign w_push    = |w_grant;
   assign w_sel     = w_grant[1];

   assign w_op   = w_sel ? req_op[2*DATA_WIDTH_ALU_OP-1:DATA_WIDTH_ALU_OP] : req_op[DATA_WIDTH_ALU_OP-1:0];
   assign w_in_0 = w_sel ? req_in_0[2*DATA_WIDTH_GPR-1:DATA_WIDTH_GPR]   : req_in_0[DATA_WIDTH_GPR-1:0];
   assign w_in_1 = w_sel ? req_in_1[2*DATA_WIDTH_GPR-1:DATA_WIDTH_GPR]   : req_in_1[DATA_WIDTH_GPR-1:0];
   assign w_tag  = w_sel ? req_tag[2*TAG_W-1:TAG_W]                      : req_tag[TAG_W-1:0];

   alu_share_arb_alu u_alu (
      .i_op     (w_op),
      .i_in_0   (w_in_0),
      .i_in_1   (w_in_1),
      .o_result (w_result)
   );

   assign w_push_pld = {(w_sel ? ARB_ID_AGU : ARB_ID_EX), w_tag, w_result};

   // Payload storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_pld;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_prio   <= c_RR_INIT;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_PTR_W'(RSP_DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
            r_prio   <= ~w_sel;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_PTR_W'(RSP_DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_W'(1);
            2'b01:   r_count <= r_count - c_CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head = rsp_valid ? r_mem[r_rd_ptr] : '0;
   assign {rsp_id, rsp_tag, rsp_data} = w_head;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
// ============================================================================
// tb_alu_share_arb : directed and random stimulus against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_arb;
   import alu_share_arb_pkg::*;

   localparam int TAG_W     = 4;
   localparam int RSP_DEPTH = 2;
   localparam int RR_INIT   = 0;

   typedef struct {
      logic        id;
      logic [3:0]  tag;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  v;
   logic [3:0]  op0, op1;
   logic [31:0] a0, b0, a1, b1;
   logic [3:0]  t0, t1;
   logic        rr;

   logic [1:0]  req_ready;
   logic        rsp_valid, rsp_id, busy;
   logic [3:0]  rsp_tag;
   logic [31:0] rsp_data;

   int   n_cmp = 0;
   int   n_bad = 0;
   ent_t q[$];
   logic m_prio;

   always #5 clk = ~clk;

   alu_share_arb #(.TAG_W(TAG_W), .RSP_DEPTH(RSP_DEPTH), .RR_INIT(RR_INIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (v),
      .req_ready (req_ready),
      .req_op    ({op1, op0}),
      .req_in_0  ({a1, a0}),
      .req_in_1  ({b1, b0}),
      .req_tag   ({t1, t0}),
      .rsp_valid (rsp_valid),
      .rsp_ready (rr),
      .rsp_id    (rsp_id),
      .rsp_tag   (rsp_tag),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         ALU_OP_ADD:  return a + b;
         ALU_OP_SUB:  return a - b;
         ALU_OP_AND:  return a & b;
         ALU_OP_OR:   return a | b;
         ALU_OP_XOR:  return a ^ b;
         ALU_OP_SLL:  return a << sh;
         ALU_OP_SRL:  return a >> sh;
         ALU_OP_SRA:  return $signed(a) >>> sh;
         ALU_OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         default:     return 32'd0;
      endcase
   endfunction

   task automatic drive(input logic [1:0] vv,
                        input logic [3:0] o0, input logic [31:0] x0, input logic [31:0] y0, input logic [3:0] g0,
                        input logic [3:0] o1, input logic [31:0] x1, input logic [31:0] y1, input logic [3:0] g1,
                        input logic r);
      v = vv; op0 = o0; a0 = x0; b0 = y0; t0 = g0;
      op1 = o1; a1 = x1; b1 = y1; t1 = g1; rr = r;
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model.
   task automatic cycle();
      logic       can, pop;
      logic [1:0] g;
      ent_t       e, h;
      #1;
      pop = (q.size() > 0) && rr;
      can = !rst && ((q.size() < RSP_DEPTH) || pop);
      g   = 2'b00;
      if (can) begin
         if (v == 2'b11)      g = m_prio ? 2'b10 : 2'b01;
         else                 g = v;
      end
      h = '{id: 1'b0, tag: 4'd0, data: 32'd0};
      if (q.size() > 0) h = q[0];
      chk("req_ready", {30'd0, req_ready}, {30'd0, g});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, (q.size() > 0)});
      chk("busy",      {31'd0, busy},      {31'd0, (q.size() > 0)});
      chk("rsp_id",    {31'd0, rsp_id},    {31'd0, h.id});
      chk("rsp_tag",   {28'd0, rsp_tag},   {28'd0, h.tag});
      chk("rsp_data",  rsp_data,           h.data);
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_prio = (RR_INIT != 0);
      end else begin
         if (pop) void'(q.pop_front());
         if (g != 2'b00) begin
            if (g[1]) e = '{id: 1'b1, tag: t1, data: ref_alu(op1, a1, b1)};
            else      e = '{id: 1'b0, tag: t0, data: ref_alu(op0, a0, b0)};
            q.push_back(e);
            m_prio = ~g[1];
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic r);
      drive(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, r);
      cycle();
   endtask

   initial begin
      rst = 1'b1;
      m_prio = (RR_INIT != 0);
      drive(2'b11, ALU_OP_ADD, 32'd1, 32'd2, 4'd1, ALU_OP_ADD, 32'd3, 32'd4, 4'd2, 1'b0);
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;
      idle(1'b1);

      // Single request: result visible the next cycle, busy clears after the pop.
      drive(2'b01, ALU_OP_ADD, 32'd5, 32'd7, 4'd3, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
      cycle();
      idle(1'b1);
      idle(1'b1);

      // Both requesting every cycle: grants alternate.
      for (int i = 0; i < 6; i++) begin
         drive(2'b11, ALU_OP_ADD, 32'(i), 32'd100, 4'(i), ALU_OP_SUB, 32'd10, 32'd3, 4'(8 + i), 1'b1);
         cycle();
      end
      idle(1'b1);
      idle(1'b1);

      // Back-pressure: two fit, the third stalls until the consumer pops.
      for (int i = 0; i < 4; i++) begin
         drive(2'b01, ALU_OP_XOR, 32'hA5A5_0000 + 32'(i), 32'h0F0F, 4'(i), 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
         cycle();
      end
      drive(2'b01, ALU_OP_XOR, 32'hA5A5_0002, 32'h0F0F, 4'd2, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
      cycle();
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Full FIFO with simultaneous push and pop for six cycles.
      for (int i = 0; i < 2; i++) begin
         drive(2'b01, ALU_OP_OR, 32'd0, 32'(i), 4'(i), 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
         cycle();
      end
      for (int i = 2; i < 8; i++) begin
         drive(2'b01, ALU_OP_OR, 32'd0, 32'(i), 4'(i & 15), 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
         cycle();
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Reset with entries queued and the pointer moved off its initial value.
      drive(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, ALU_OP_ADD, 32'd1, 32'd1, 4'd9, 1'b0);
      cycle();
      drive(2'b01, ALU_OP_ADD, 32'd2, 32'd2, 4'd7, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
      cycle();
      rst = 1'b1;
      idle(1'b0);
      rst = 1'b0;
      drive(2'b11, ALU_OP_ADD, 32'd4, 32'd4, 4'd4, ALU_OP_ADD, 32'd5, 32'd5, 4'd5, 1'b1);
      cycle();
      idle(1'b1);
      idle(1'b1);

      // Arithmetic shift right and an undefined op code.
      drive(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, ALU_OP_SRA, 32'h8000_0000, 32'd4, 4'd6, 1'b1);
      cycle();
      drive(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 4'd14, 32'h1234_5678, 32'd9, 4'd11, 1'b1);
      cycle();
      idle(1'b1);
      idle(1'b1);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 600; i++) begin
         drive(2'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
               4'($urandom), 4'($urandom), $urandom, $urandom, 4'($urandom), ($urandom_range(0, 3) != 0));
         rst = ($urandom_range(0, 59) == 0);
         cycle();
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
